// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and decode helper for the registered 4-bit subtractor
package sub_pkg;

    localparam int OPND_W = 4;
    localparam int DIFF_W = 5;

    typedef struct packed {
        logic              borrow;
        logic [OPND_W-1:0] mag;
        logic [DIFF_W-1:0] diff;
    } sub_result_t;

    // Split a raw difference into sign and magnitude; z=16 falls out as borrow=1, mag=0
    function automatic sub_result_t decode_z(input logic [DIFF_W-1:0] z);
        sub_result_t       r;
        logic [OPND_W-1:0] neg;
        neg      = ~z[OPND_W-1:0] + OPND_W'(1);
        r.diff   = z;
        r.borrow = z[DIFF_W-1];
        r.mag    = r.borrow ? neg : z[OPND_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sub_sync_fifo.sv
// rtl/sub_sync_fifo.sv - first-word fall-through FIFO holding decoded subtractor results
module sub_sync_fifo
    import sub_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = sub_result_t
) (
    input  logic                     sclk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  T                         wr_data,
    input  logic                     rd_en,
    output T                         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    // The caller only raises wr_en when not full (or popping) and rd_en when not empty
    T              mem [DEPTH];
    T              held;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = empty ? held : mem[rd_ptr];

    // Storage write; contents need no reset because level gates visibility
    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy
    always_ff @(posedge sclk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Remember the current head so the output holds its last value once the FIFO empties
    always_ff @(posedge sclk) begin
        if (srst) begin
            held <= '0;
        end else if (!empty) begin
            held <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/sub_result_buffer.sv
// rtl/sub_result_buffer.sv - aligns, decodes and queues subtractor results; optional SUB_STATS_EN counters
module sub_result_buffer
    import sub_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       sclk,
    input  logic                       srst,
    input  logic                       op_valid,
    input  logic [DIFF_W-1:0]          z_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIFF_W-1:0]          out_diff,
    output logic                       out_borrow,
    output logic [OPND_W-1:0]          out_mag,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop_err
`ifdef SUB_STATS_EN
    ,
    output logic [CNT_W-1:0]           neg_cnt,
    output logic [CNT_W-1:0]           zero_cnt
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
        $error("sub_result_buffer: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    logic        vld_d1;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        drop;
    sub_result_t res;
    sub_result_t head;

    assign res       = decode_z(z_in);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = vld_d1 & (~full | pop);
    assign drop      = vld_d1 & full & ~pop;

    assign out_diff   = head.diff;
    assign out_borrow = head.borrow;
    assign out_mag    = head.mag;

    // Delay the operand strobe by the subtractor's register so it lines up with z_in
    always_ff @(posedge sclk) begin
        if (srst) vld_d1 <= 1'b0;
        else      vld_d1 <= op_valid;
    end

    // Sticky overflow flag: a result arrived with nowhere to go
    always_ff @(posedge sclk) begin
        if (srst)      drop_err <= 1'b0;
        else if (drop) drop_err <= 1'b1;
    end

    sub_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (sub_result_t)
    ) u_fifo (
        .sclk    (sclk),
        .srst    (srst),
        .wr_en   (push),
        .wr_data (res),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

`ifdef SUB_STATS_EN
    // Saturating counts of accepted negative and zero results
    always_ff @(posedge sclk) begin
        if (srst) begin
            neg_cnt  <= '0;
            zero_cnt <= '0;
        end else if (push) begin
            if (res.borrow && neg_cnt != '1)
                neg_cnt <= neg_cnt + CNT_W'(1);
            if (res.diff == '0 && zero_cnt != '1)
                zero_cnt <= zero_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
